// File: rtl/addr_router_switch.sv
// rtl/addr_router_switch.sv - two-way address router with registered ports A/B (optional macro: SWITCH_IDLE_CLEAR_EN)
module addr_router_switch #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DIV = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  vld,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b
);

    logic to_a;

    // Unsigned compare: the divider address itself belongs to port A.
    always_comb begin
        to_a = (addr <= ADDR_DIV);
    end

    // Steer each valid beat to one port and zero the other; idle edges hold or clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_a <= '0;
            data_a <= '0;
            addr_b <= '0;
            data_b <= '0;
        end else if (vld) begin
            if (to_a) begin
                addr_a <= addr;
                data_a <= data;
                addr_b <= '0;
                data_b <= '0;
            end else begin
                addr_a <= '0;
                data_a <= '0;
                addr_b <= addr;
                data_b <= data;
            end
        end else begin
`ifdef SWITCH_IDLE_CLEAR_EN
            addr_a <= '0;
            data_a <= '0;
            addr_b <= '0;
            data_b <= '0;
`else
            addr_a <= addr_a;
            data_a <= data_a;
            addr_b <= addr_b;
            data_b <= data_b;
`endif
        end
    end

endmodule

// File: tb/tb_addr_router_switch.sv
// tb/tb_addr_router_switch.sv - self-checking bench for addr_router_switch
module tb_addr_router_switch;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [AW-1:0] DIV = 8'h3F;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          vld;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;

    int errors = 0;
    int checks = 0;

    // Reference view of the two output ports.
    logic [AW-1:0] m_addr_a, m_addr_b;
    logic [DW-1:0] m_data_a, m_data_b;

    addr_router_switch #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ADDR_DIV(DIV)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .addr(addr),
        .data(data),
        .vld(vld),
        .addr_a(addr_a),
        .data_a(data_a),
        .addr_b(addr_b),
        .data_b(data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".addr_a"}, DW'(addr_a), DW'(m_addr_a));
        chk({tag, ".data_a"}, data_a, m_data_a);
        chk({tag, ".addr_b"}, DW'(addr_b), DW'(m_addr_b));
        chk({tag, ".data_b"}, data_b, m_data_b);
    endtask

    task automatic model_clear();
        m_addr_a = '0;
        m_data_a = '0;
        m_addr_b = '0;
        m_data_b = '0;
    endtask

    // Routing rule applied at a rising edge with reset released.
    task automatic model_edge(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (v) begin
            model_clear();
            if (int'(a) <= int'(DIV)) begin
                m_addr_a = a;
                m_data_a = d;
            end else begin
                m_addr_b = a;
                m_data_b = d;
            end
        end else begin
`ifdef SWITCH_IDLE_CLEAR_EN
            model_clear();
`endif
        end
    endtask

    // Present one beat, take one edge, then compare just after the edge.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        vld  = v;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        if (rstn) model_edge(v, a, d);
        else model_clear();
        chk_all(tag);
    endtask

    initial begin
        rstn = 1'b1;
        vld  = 1'b0;
        addr = '0;
        data = '0;
        model_clear();

        // Power-on reset, asserted between edges.
        #2 rstn = 1'b0;
        #1 chk_all("por");
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Preload both ports, then check asynchronous clear mid-cycle.
        step(1'b1, 8'h10, 16'h1234, "pre_a");
        step(1'b1, 8'h80, 16'h5678, "pre_b");
        #2 rstn = 1'b0;
        #1 model_clear();
        chk_all("async_rst");
        step(1'b1, 8'h22, 16'h9999, "beat_in_rst");
        rstn = 1'b1;
        step(1'b0, 8'h00, 16'h0000, "post_rel_idle");

        // Basic routing to each port.
        step(1'b1, 8'h05, 16'hBEEF, "route_a");
        step(1'b1, 8'hC3, 16'h1234, "route_b");

        // Boundaries on consecutive cycles.
        step(1'b1, 8'h3F, 16'hAAAA, "bnd_div");
        step(1'b1, 8'h40, 16'h5555, "bnd_div1");
        step(1'b1, 8'h00, 16'h0000, "bnd_zero");
        step(1'b1, 8'hFF, 16'hC0DE, "bnd_ones");

        // Hold (default) or clear (idle-clear build) across idle cycles.
        step(1'b1, 8'h20, 16'h0F0F, "hold_beat");
        step(1'b0, 8'h7E, 16'hDEAD, "idle1");
        step(1'b0, 8'h01, 16'hBEEF, "idle2");
        step(1'b0, 8'hF0, 16'h1111, "idle3");

        // Random stream with a reset pulse in the middle.
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                #2 rstn = 1'b0;
                #1 model_clear();
                chk_all("rnd_rst");
                step(1'b1, AW'($urandom), DW'($urandom), "rnd_in_rst");
                rstn = 1'b1;
            end
            step(($urandom_range(0, 3) != 0), AW'($urandom), DW'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
